alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-phase issue controller for an external 16-bit ALU (optional ALU_ILLEGAL_TRAP_EN)
module alu_issue_ctrl #(
    parameter logic [15:0] REG_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        zero_flag,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;

    state_t      state, state_next;
    logic [15:0] instr;
    logic [15:0] regs [0:7];
    logic [15:0] res;
    logic        res_zero;

    logic [2:0]  f_op, f_rd, f_rs, f_rt;
    logic [15:0] imm_sext;
    logic        illegal;
    logic        accept;

    assign f_op     = instr[15:13];
    assign f_rd     = instr[12:10];
    assign f_rs     = instr[9:7];
    assign f_rt     = instr[6:4];
    assign imm_sext = {{9{instr[6]}}, instr[6:0]};
    assign illegal  = (f_op != OP_ADD) && (f_op != OP_ADDI) && (f_op != OP_SUBI);

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;

    // r0 is never written, so indexing the array directly already yields 0 for it
    assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: one cycle in each working phase; illegal ops either trap or fall through as a NOP
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_READ;
            S_READ: state_next = S_EXEC;
            S_EXEC: begin
`ifdef ALU_ILLEGAL_TRAP_EN
                if (illegal) state_next = S_HALT;
                else         state_next = S_WB;
`else
                state_next = S_WB;
`endif
            end
            S_WB:   state_next = S_IDLE;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // datapath: instruction latch, operand staging, result capture and write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            instr     <= 16'h0000;
            alu_op    <= 3'd0;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            res       <= 16'h0000;
            res_zero  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 3'd0;
            wb_data   <= 16'h0000;
            zero_flag <= 1'b0;
            err       <= 1'b0;
            regs[0]   <= 16'h0000;
            for (int i = 1; i < 8; i++) begin
                regs[i] <= REG_INIT;
            end
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) instr <= in_instr;
                end
                S_READ: begin
                    alu_op <= f_op;
                    alu_a  <= regs[f_rs];
                    alu_b  <= (f_op == OP_ADD) ? regs[f_rt] : imm_sext;
                end
                S_EXEC: begin
                    res      <= alu_result;
                    res_zero <= alu_zero;
`ifdef ALU_ILLEGAL_TRAP_EN
                    if (illegal) err <= 1'b1;
`endif
                end
                S_WB: begin
                    if (!illegal) begin
                        wb_valid  <= 1'b1;
                        wb_rd     <= f_rd;
                        wb_data   <= res;
                        zero_flag <= res_zero;
                        if (f_rd != 3'd0) regs[f_rd] <= res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        zero_flag;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int          pulses, first, rdy4;
    logic [15:0] got_data;
    logic [2:0]  got_rd;

    alu_issue_ctrl #(.REG_INIT(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .zero_flag(zero_flag), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // external ALU
    always_comb begin
        alu_result = 16'h0000;
        case (alu_op)
            3'b000, 3'b001: alu_result = alu_a + alu_b;
            3'b010:         alu_result = alu_a - alu_b;
            default:        alu_result = 16'h0000;
        endcase
        alu_zero = (alu_result == 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // issue one instruction from a negedge; watch 5 cycles after the handshake edge
    task automatic run(input logic [15:0] ins, output int np, output int fi, output int r4,
                       output logic [2:0] rd, output logic [15:0] d);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
        np = 0; fi = 0; r4 = 0; rd = 3'd0; d = 16'h0000;
        for (int i = 1; i <= 5; i++) begin
            if (wb_valid) begin
                np++;
                if (fi == 0) begin
                    fi = i;
                    rd = wb_rd;
                    d  = wb_data;
                end
            end
            if (i == 4) r4 = int'(in_ready);
            @(negedge clk);
        end
    endtask

    logic [15:0] rv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; dbg_addr = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_zero", {31'd0, zero_flag}, 32'd0);
        chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
        dbg(3'd1, rv);
        chk("rst_r1", {16'd0, rv}, 32'd0);

        // ADDI r1,r0,+5
        run(16'h2405, pulses, first, rdy4, got_rd, got_data);
        chk("addi_pulses", pulses, 1);
        chk("addi_latency", first, 4);
        chk("addi_rd", {29'd0, got_rd}, 32'd1);
        chk("addi_data", {16'd0, got_data}, 32'h0005);
        chk("addi_zero", {31'd0, zero_flag}, 32'd0);
        chk("addi_alu_op_hold", {29'd0, alu_op}, 32'd1);
        chk("addi_alu_b_hold", {16'd0, alu_b}, 32'h0005);
        dbg(3'd1, rv);
        chk("addi_r1", {16'd0, rv}, 32'h0005);

        // ADDI r2,r0,-3 then dependent ADD r3,r1,r2
        run(16'h287D, pulses, first, rdy4, got_rd, got_data);
        chk("addi_neg_data", {16'd0, got_data}, 32'hFFFD);
        run(16'h0CA0, pulses, first, rdy4, got_rd, got_data);
        chk("add_rd", {29'd0, got_rd}, 32'd3);
        chk("add_data", {16'd0, got_data}, 32'h0002);

        // build r1 = 0x7FFF: 1, doubled 15 times, minus 1
        run(16'h2401, pulses, first, rdy4, got_rd, got_data);
        for (int k = 0; k < 15; k++) run(16'h0490, pulses, first, rdy4, got_rd, got_data);
        chk("dbl_data", {16'd0, got_data}, 32'h8000);
        run(16'h4481, pulses, first, rdy4, got_rd, got_data);
        chk("subi_7fff", {16'd0, got_data}, 32'h7FFF);
        run(16'h2481, pulses, first, rdy4, got_rd, got_data);
        chk("wrap_data", {16'd0, got_data}, 32'h8000);
        chk("wrap_zero", {31'd0, zero_flag}, 32'd0);

        // SUBI r4,r1,1 with r1 = 1
        run(16'h2401, pulses, first, rdy4, got_rd, got_data);
        run(16'h5081, pulses, first, rdy4, got_rd, got_data);
        chk("subi_rd", {29'd0, got_rd}, 32'd4);
        chk("subi_data", {16'd0, got_data}, 32'h0000);
        chk("subi_zero", {31'd0, zero_flag}, 32'd1);

        // ADDI r0,r0,+7
        run(16'h2007, pulses, first, rdy4, got_rd, got_data);
        chk("r0_pulses", pulses, 1);
        chk("r0_rd", {29'd0, got_rd}, 32'd0);
        chk("r0_data", {16'd0, got_data}, 32'h0007);
        dbg(3'd0, rv);
        chk("r0_reads_zero", {16'd0, rv}, 32'd0);

        // illegal op 111 targeting r1
        run(16'hE405, pulses, first, rdy4, got_rd, got_data);
        chk("ill_pulses", pulses, 0);
        dbg(3'd1, rv);
        chk("ill_r1_kept", {16'd0, rv}, 32'h0001);
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_ready_c4", rdy4, 0);
        repeat (4) @(negedge clk);
        chk("ill_halt_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ill_rst_err", {31'd0, err}, 32'd0);
        chk("ill_rst_ready", {31'd0, in_ready}, 32'd1);
`else
        chk("ill_err", {31'd0, err}, 32'd0);
        chk("ill_ready_c4", rdy4, 1);
`endif

        // reset during EXEC of ADDI r5,r0,+9
        in_valid = 1'b1;
        in_instr = 16'h3409;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (wb_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_pulses", pulses, 0);
        dbg(3'd5, rv);
        chk("abort_r5", {16'd0, rv}, 32'h0000);
        dbg(3'd1, rv);
        chk("abort_r1_init", {16'd0, rv}, 32'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
